// File: rtl/fifo_frame_reader_pkg.sv
// ============================================================================
// fifo_frame_reader_pkg : shared state encoding and sizing helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_REWIND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int PASS_W = 8;

    // Bits needed to hold the value itself, so a counter can reach FRAME_LEN.
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_frame_reader_skid.sv
// ============================================================================
// stream_skid_buffer : 2-entry in-order buffer with valid/ready output side
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_skid_buffer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign push      = s_valid_i && (count_q != 2'd2);
    assign pop       = m_valid_o && m_ready_i;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_frame_reader.sv
// ============================================================================
// fifo_frame_reader : reads FRAME_LEN samples from a sync FIFO, replays PASS_NUM times
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 784,
    parameter int PASS_NUM   = 1,
    parameter int CW         = clogb2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_out,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_rewind,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [7:0]            m_pass,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CW-1:0]     FRAME_CNT = CW'(FRAME_LEN);
    localparam logic [CW-1:0]     LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASS_NUM - 1);

    state_t              state_q;
    logic [CW-1:0]       rd_cnt_q;
    logic [CW-1:0]       out_cnt_q;
    logic [PASS_W-1:0]   pass_q;
    logic                inflight_q;
    logic                inflight_last_q;

    logic                buf_valid;
    logic [DATA_WIDTH:0] buf_data;
    logic [1:0]          buf_count;
    logic                xfer;
    logic                last_xfer;
    logic [2:0]          in_use;

    stream_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (inflight_q),
        .s_data_i  ({inflight_last_q, fifo_out}),
        .m_valid_o (buf_valid),
        .m_ready_i (m_ready),
        .m_data_o  (buf_data),
        .count_o   (buf_count)
    );

    assign xfer      = buf_valid && m_ready;
    assign last_xfer = xfer && buf_data[DATA_WIDTH];

    // The slot freed by this cycle's transfer counts as available, giving 1 sample/cycle.
    assign in_use = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, xfer};

    assign fifo_rd_en     = (state_q == ST_READ) && !fifo_empty
                            && (rd_cnt_q < FRAME_CNT) && (in_use < 3'd2);
    assign fifo_rd_rewind = (state_q == ST_REWIND);
    assign done           = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign m_valid        = buf_valid;
    assign m_data         = buf_data[DATA_WIDTH-1:0];
    assign m_last         = buf_valid && buf_data[DATA_WIDTH];
    assign m_pass         = pass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rd_cnt_q        <= '0;
            out_cnt_q       <= '0;
            pass_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= fifo_rd_en;
            inflight_last_q <= fifo_rd_en && (rd_cnt_q == LAST_IDX);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_READ;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        pass_q    <= '0;
                    end
                end
                ST_READ: begin
                    if (fifo_rd_en) begin
                        rd_cnt_q <= rd_cnt_q + CW'(1);
                    end
                    if (xfer) begin
                        out_cnt_q <= out_cnt_q + CW'(1);
                    end
                    // The last sample leaving means every read of the pass has drained.
                    if (last_xfer) begin
                        state_q <= (pass_q == PASS_LAST) ? ST_DONE : ST_REWIND;
                    end
                end
                ST_REWIND: begin
                    pass_q    <= pass_q + PASS_W'(1);
                    rd_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    state_q   <= ST_READ;
                end
                ST_DONE: begin
                    pass_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// ============================================================================
// tb_fifo_frame_reader : scoreboard bench with behavioural upstream FIFO
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_frame_reader;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int PN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_out = '0;
    logic          fifo_rd_en;
    logic          fifo_rd_rewind;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [7:0]    m_pass;
    logic          busy;
    logic          done;

    fifo_frame_reader #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .PASS_NUM   (PN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fifo_empty     (fifo_empty),
        .fifo_out       (fifo_out),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_rewind (fifo_rd_rewind),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_pass         (m_pass),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Upstream sync FIFO: f_wr words are available, read data appears one cycle after the read.
    logic [DW-1:0] fmem [FL];
    int            f_wr = 0;
    int            f_rd = 0;
    logic          f_clr = 1'b0;

    assign fifo_empty = (f_rd >= f_wr);

    always @(posedge clk) begin
        if (f_clr || fifo_rd_rewind) begin
            f_rd <= 0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_out <= fmem[f_rd];
            f_rd     <= f_rd + 1;
        end
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [7:0]    p;
    } exp_t;

    exp_t    sb[$];
    int      xq[$];
    exp_t    e;
    int      n_cmp = 0;
    int      n_mis = 0;
    int      cyc = 0;
    int      n_rew = 0;
    int      n_done = 0;
    int      n_xfer = 0;
    bit      mon_en = 1'b0;
    logic    prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic    prev_l = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && mon_en) begin
            if (prev_stall) begin
                n_cmp = n_cmp + 1;
                if (!m_valid || m_data !== prev_d || m_last !== prev_l) begin
                    n_mis = n_mis + 1;
                    $display("FAIL stall_hold: valid=%0b data=%0h last=%0b, required valid=1 data=%0h last=%0b",
                             m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (fifo_rd_en) begin
                n_cmp = n_cmp + 1;
                if (fifo_empty || fifo_rd_rewind) begin
                    n_mis = n_mis + 1;
                    $display("FAIL rd_en_guard: empty=%0b rewind=%0b, required both 0", fifo_empty, fifo_rd_rewind);
                end
            end
            if (fifo_rd_rewind) begin
                n_rew = n_rew + 1;
                n_cmp = n_cmp + 1;
                if ((sb.size() % FL) != 0 || m_valid) begin
                    n_mis = n_mis + 1;
                    $display("FAIL rewind_early: pending=%0d valid=%0b, required pass fully delivered",
                             sb.size(), m_valid);
                end
            end
            if (done) n_done = n_done + 1;
            if (m_valid && m_ready) begin
                n_cmp  = n_cmp + 1;
                n_xfer = n_xfer + 1;
                xq.push_back(cyc);
                if (sb.size() == 0) begin
                    n_mis = n_mis + 1;
                    $display("FAIL unexpected_out: data=%0h last=%0b pass=%0d, required no output",
                             m_data, m_last, m_pass);
                end else begin
                    e = sb.pop_front();
                    if ({m_data, m_last, m_pass} !== e) begin
                        n_mis = n_mis + 1;
                        $display("FAIL sample: data=%0h last=%0b pass=%0d, required data=%0h last=%0b pass=%0d",
                                 m_data, m_last, m_pass, e.d, e.l, e.p);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        n_cmp = n_cmp + 1;
        if (got != req) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, int'({fifo_rd_en, fifo_rd_rewind, m_valid, m_last, busy, done, m_data, m_pass}), 0);
    endtask

    task automatic load(input int base, input int avail);
        f_clr = 1'b1;
        f_wr  = 0;
        for (int i = 0; i < FL; i++) fmem[i] = DW'(base + i);
        tick();
        f_clr = 1'b0;
        f_wr  = avail;
    endtask

    task automatic push_exp(input int base);
        for (int p = 0; p < PN; p++)
            for (int i = 0; i < FL; i++)
                sb.push_back({DW'(base + i), (i == FL - 1), 8'(p)});
        n_rew  = 0;
        n_done = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (n_done == 0 && t < 1000) begin
            tick();
            t++;
        end
        check(name, n_done, 1);
        tick(2);
    endtask

    task automatic check_end(input string name);
        check({name, "_pending"}, sb.size(), 0);
        check({name, "_rewinds"}, n_rew, PN - 1);
        check({name, "_done_pulses"}, n_done, 1);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_pass_idle"}, int'(m_pass), 0);
    endtask

    initial begin
        int x0;
        int t;

        tick(3);
        check_zero("reset_outputs");
        rst_n = 1'b1;
        tick(2);
        check_zero("idle_after_reset");
        mon_en = 1'b1;

        // Full-rate replay of 0..7, three passes.
        load(0, FL);
        push_exp(0);
        xq.delete();
        pulse_start();
        wait_done("t1_done");
        check_end("t1");
        check("t1_pass0_rate", xq[FL-1] - xq[0], FL - 1);
        check("t1_pass2_rate", xq[3*FL-1] - xq[2*FL], FL - 1);

        // Random backpressure plus a start pulse while busy.
        ready_mode = 1;
        load(16'h100, FL);
        push_exp(16'h100);
        pulse_start();
        tick(5);
        check("t2_busy_mid", int'(busy), 1);
        pulse_start();
        wait_done("t2_done");
        check_end("t2");
        ready_mode = 0;

        // Upstream delivers one word every third cycle.
        load(16'h200, 0);
        push_exp(16'h200);
        pulse_start();
        for (int i = 1; i <= FL; i++) begin
            tick(3);
            f_wr = i;
        end
        wait_done("t3_done");
        check_end("t3");

        // Asynchronous reset after four samples, then a clean frame.
        load(16'h300, FL);
        push_exp(16'h300);
        x0 = n_xfer;
        pulse_start();
        t = 0;
        while (n_xfer < x0 + 4 && t < 200) begin
            tick();
            t++;
        end
        check("t4_reached_sample4", n_xfer - x0, 4);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_zero("t4_async_reset");
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("t4_waits_for_start", int'(busy), 0);
        mon_en = 1'b1;
        load(16'h400, FL);
        push_exp(16'h400);
        pulse_start();
        wait_done("t4_done");
        check_end("t4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the sample width in bits.
REQ-002 Parameter FRAME_LEN, default 784, sets the samples per frame and matches the upstream FIFO BUF_SIZE.
REQ-003 Parameter PASS_NUM, default 1, sets the number of times each frame is replayed (1..255).
REQ-004 Parameter CW, default clogb2(FRAME_LEN), sets the sample counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: a 1-cycle pulse that begins a frame read.
REQ-008 Port fifo_empty, input, 1 bit: empty flag from the upstream sync FIFO.
REQ-009 Port fifo_out, input, DATA_WIDTH bits: FIFO read data, valid 1 cycle after an accepted read.
REQ-010 Port fifo_rd_en, output, 1 bit: FIFO read request.
REQ-011 Port fifo_rd_rewind, output, 1 bit: 1-cycle pulse that rewinds the FIFO read pointer to 0.
REQ-012 Port m_valid, output, 1 bit: output sample valid.
REQ-013 Port m_ready, input, 1 bit: downstream ready.
REQ-014 Port m_data, output, DATA_WIDTH bits: output sample.
REQ-015 Port m_last, output, 1 bit: marks the last sample of a pass.
REQ-016 Port m_pass, output, 8 bits: index of the current pass, starting at 0.
REQ-017 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 Port done, output, 1 bit: 1-cycle pulse when the final pass completes.

Function
REQ-019 The state machine SHALL have the states IDLE, READ, REWIND and DONE, with IDLE as the reset state.
REQ-020 In IDLE, start=1 SHALL go to READ and clear rd_cnt, out_cnt and pass; start is ignored in every other state.
REQ-021 In READ, fifo_rd_en SHALL be asserted only when all of the following hold:
- fifo_empty=0;
- rd_cnt < FRAME_LEN;
- buffer occupancy + in-flight reads < 2.
REQ-022 An accepted read (fifo_rd_en & !fifo_empty) SHALL increment rd_cnt and mark one in-flight read.
- The next cycle, fifo_out SHALL be captured into the 2-entry output buffer.
REQ-023 Output handshake: a transfer SHALL occur when m_valid & m_ready.
- m_data, m_last and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 No sample SHALL be dropped or duplicated; with m_ready held at 1 and the FIFO non-empty, throughput SHALL be 1 sample per cycle after a 2-cycle initial latency.
REQ-025 m_last SHALL be 1 exactly on the transfer where out_cnt == FRAME_LEN-1.
REQ-026 When the m_last transfer occurs with pass < PASS_NUM-1, the block SHALL go to REWIND.
REQ-027 REWIND SHALL last one cycle: fifo_rd_rewind=1, pass increments, rd_cnt and out_cnt clear, then return to READ.
REQ-028 When the m_last transfer occurs with pass == PASS_NUM-1, the block SHALL go to DONE.
REQ-029 DONE SHALL last one cycle: done=1, then return to IDLE.
REQ-030 fifo_rd_rewind SHALL never coincide with fifo_rd_en.
- All reads of a pass SHALL be accepted and all of its samples delivered before rewind is issued.
REQ-031 If fifo_empty rises mid-frame, reads SHALL stall without error and resume when fifo_empty falls; m_valid drops once the buffer drains.
REQ-032 Counters SHALL be CW bits wide; rd_cnt saturates at FRAME_LEN and never wraps.
REQ-033 m_pass SHALL hold the current pass index, held at 0 in IDLE.

Reset
REQ-034 On rst_n=0, regardless of the current state, the block SHALL asynchronously:
- go to IDLE;
- empty the buffer and clear the in-flight mark, all counters and pass;
- drive fifo_rd_en, fifo_rd_rewind, m_valid, m_last, busy and done to 0, and m_data and m_pass to 0.
REQ-035 After reset is released mid-frame, the block SHALL wait for start; the upstream FIFO is cleared separately via its clear input.

Structure
REQ-036 The clogb2 function and the state encodings SHALL live in a shared include header used by the FIFO and reader modules.
REQ-037 The 2-entry output buffer SHALL be the sub-module stream_skid_buffer (DATA_WIDTH+1 bits wide, carrying data and last).
REQ-038 The FSM, counters and read-issue logic SHALL be in fifo_frame_reader.

Verification
REQ-039 FRAME_LEN=8, PASS_NUM=1, FIFO preloaded with 0..7, m_ready=1, start pulse -> m_data is 0..7 on consecutive cycles, m_last on 7, then done 1 cycle later, never any rewind.
REQ-040 PASS_NUM=3, same data -> three bursts of 0..7, m_pass 0/1/2, exactly 2 fifo_rd_rewind pulses, each between bursts, and no rd_en in those cycles.
REQ-041 Random m_ready at 50% -> output sequence is exactly 0..7 with no loss or duplication, and data is stable during stalls.
REQ-042 FIFO fed at 1 word every 3 cycles -> fifo_rd_en is never asserted while fifo_empty=1, and output is correct.
REQ-043 rst_n pulled low at sample 4 -> all outputs are 0 that cycle; a subsequent FIFO clear and start produce a clean frame.
REQ-044 start pulsed while busy=1 -> no effect; the frame completes normally.
